engine_stream_arbiter: RTL

- Packet-granular round-robin arbiter that shares the single Aggregator input path between engine 1 and engine 2.
- Each engine presents a 256-bit beat stream with valid/ready/last framing.
- The arbiter grants one engine for a whole packet and forwards its beats through one registered output stage.
- It tags each beat with its source and reports the packet beat count on the final beat.

---
 rtl/engine_stream_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/engine_stream_arbiter.sv
// Packet-granular round-robin arbiter: two 256-bit beat streams share one
// registered output stage. A grant lasts for a whole packet; every output
// beat carries its source id, and the final beat carries the packet length.

// Per-engine handshake slice: an engine is ready only while it holds the
// grant and the output register can take a beat this cycle.
module engine_port (
  input  logic grant,
  input  logic out_free,
  input  logic in_valid,
  output logic ready,
  output logic accept
);
  assign ready  = grant & out_free;
  assign accept = in_valid & ready;
endmodule

module engine_stream_arbiter #(
  parameter int DATA_WIDTH   = 255,
  parameter int LENGTH_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_1,
  input  logic                  last_1,
  input  logic [DATA_WIDTH:0]   DATA_IN1,
  output logic                  ready_1,
  input  logic                  valid_2,
  input  logic                  last_2,
  input  logic [DATA_WIDTH:0]   DATA_IN2,
  output logic                  ready_2,
  output logic [DATA_WIDTH:0]   DATA_OUT,
  output logic                  valid,
  output logic                  last,
  output logic                  src_id,
  output logic [LENGTH_WIDTH:0] pkt_len,
  input  logic                  ready,
  output logic                  busy,
  output logic                  len_err
);

  localparam int NUM_ENG = 2;

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

  state_t                         state, state_nxt;
  logic                           last_grant, last_grant_nxt; // 0 = engine 1, 1 = engine 2
  logic                           grant_entry;
  logic                           pick;

  logic [NUM_ENG-1:0]                 in_valid, in_last, grant, port_ready, port_accept;
  logic [NUM_ENG-1:0][DATA_WIDTH:0]   in_data;

  logic                           out_free;
  logic                           sel;
  logic                           accept;
  logic                           acc_last;
  logic [DATA_WIDTH:0]            acc_data;

  logic [LENGTH_WIDTH:0]          cnt, cnt_inc;
  logic                           cnt_full;

  // Gather the two engine streams into lane-indexed vectors.
  assign in_valid = {valid_2, valid_1};
  assign in_last  = {last_2, last_1};
  assign in_data  = {DATA_IN2, DATA_IN1};
  assign grant    = {state == GRANT2, state == GRANT1};

  // The output register can take a new beat when empty or being drained.
  assign out_free = !valid || ready;

  genvar g;
  generate
    for (g = 0; g < NUM_ENG; g++) begin : g_port
      engine_port u_port (
        .grant    (grant[g]),
        .out_free (out_free),
        .in_valid (in_valid[g]),
        .ready    (port_ready[g]),
        .accept   (port_accept[g])
      );
    end
  endgenerate

  assign ready_1  = port_ready[0];
  assign ready_2  = port_ready[1];

  // Only the granted lane can accept, so the grant selects the beat source.
  assign sel      = (state == GRANT2);
  assign accept   = |port_accept;
  assign acc_last = in_last[sel];
  assign acc_data = in_data[sel];

  // Beat count saturates at all-ones instead of wrapping.
  assign cnt_full = &cnt;
  assign cnt_inc  = cnt_full ? cnt : cnt + {{LENGTH_WIDTH{1'b0}}, 1'b1};

  assign busy     = (state != IDLE) || valid;

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state: grant only from IDLE, release only on an accepted last beat.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_entry    = 1'b0;
    pick           = 1'b0;
    case (state)
      IDLE: begin
        if (start && |in_valid) begin
          // On a tie, the engine that did not go last wins.
          pick           = (&in_valid) ? !last_grant : in_valid[1];
          state_nxt      = pick ? GRANT2 : GRANT1;
          last_grant_nxt = pick;
          grant_entry    = 1'b1;
        end
      end
      GRANT1, GRANT2: begin
        if (accept && acc_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-packet beat counter, restarted whenever a new grant is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (grant_entry) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt_inc;
    end
  end

  // Sticky overflow flag: a beat arrived while the counter was already full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_err <= 1'b0;
    end else if (accept && cnt_full) begin
      len_err <= 1'b1;
    end
  end

  // Output register: load on accept, drop valid when drained with no refill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DATA_OUT <= '0;
      valid    <= 1'b0;
      last     <= 1'b0;
      src_id   <= 1'b0;
      pkt_len  <= '0;
    end else if (accept) begin
      DATA_OUT <= acc_data;
      valid    <= 1'b1;
      last     <= acc_last;
      src_id   <= sel;
      pkt_len  <= cnt_inc;
    end else if (valid && ready) begin
      valid    <= 1'b0;
    end
  end

endmodule
